// File: rtl/sgr_attribute_engine.sv
// SGR attribute engine: interprets the parser's parameter stream into a working
// attribute set, commits it at END, and keeps a circular save/restore stack.
module sgr_attribute_engine #(
    parameter int CH_BITS     = 3,
    parameter int STACK_DEPTH = 4,
    parameter logic [3*CH_BITS-1:0] DEFAULT_FG = {3{CH_BITS'(8'hCD >> (8 - CH_BITS))}},
    parameter logic [3*CH_BITS-1:0] DEFAULT_BG = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [2:0]                       cmd_op,
    input  logic [7:0]                       pn,
    output logic [3*CH_BITS-1:0]             fg,
    output logic [3*CH_BITS-1:0]             bg,
    output logic [7:0]                       effects,
    output logic                             attr_update,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count
);
    localparam int CL = 3 * CH_BITS;
    localparam int AW = 2 * CL + 8;
    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] OP_INIT = 3'd1, OP_PARAM = 3'd2, OP_END = 3'd3,
                           OP_CLEAR = 3'd4, OP_SAVE = 3'd5, OP_RESTORE = 3'd6;
    localparam logic [7:0] LVL_NORM = 8'hAA, LVL_WHITE = 8'hCD, LVL_BRIGHT = 8'hFF;

    typedef enum logic [3:0] {
        S_START, S_FG_SEL, S_BG_SEL, S_FG_IDX, S_BG_IDX,
        S_FG_R, S_FG_G, S_FG_B, S_BG_R, S_BG_G, S_BG_B
    } state_t;

    function automatic logic [CH_BITS-1:0] top(input logic [7:0] v);
        return v[7 -: CH_BITS];
    endfunction

    // bit0 of sel = R, bit1 = G, bit2 = B; R occupies the MSBs of the colour
    function automatic logic [CL-1:0] mapc(input logic [2:0] sel, input logic [7:0] lvl);
        logic [CH_BITS-1:0] t;
        t = top(lvl);
        return {sel[0] ? t : {CH_BITS{1'b0}},
                sel[1] ? t : {CH_BITS{1'b0}},
                sel[2] ? t : {CH_BITS{1'b0}}};
    endfunction

    function automatic logic [7:0] step(input logic [7:0] k);
        case (k)
            8'd0:    return 8'd0;
            8'd1:    return 8'd95;
            8'd2:    return 8'd135;
            8'd3:    return 8'd175;
            8'd4:    return 8'd215;
            default: return 8'd255;
        endcase
    endfunction

    function automatic logic [CL-1:0] palette(input logic [7:0] i);
        logic [7:0] n, gr;
        if (i < 8'd8)
            return (i == 8'd7) ? mapc(3'd7, LVL_WHITE) : mapc(i[2:0], LVL_NORM);
        else if (i < 8'd16)
            return mapc(i[2:0], LVL_BRIGHT);
        else if (i < 8'd232) begin
            n = i - 8'd16;
            return {top(step(n / 8'd36)), top(step((n / 8'd6) % 8'd6)), top(step(n % 8'd6))};
        end else begin
            gr = 8'd8 + 8'd10 * (i - 8'd232);
            return {3{top(gr)}};
        end
    endfunction

    state_t          st, st_n;
    logic [CL-1:0]   c_fg, c_bg, w_fg, w_bg, fg_n, bg_n;
    logic [7:0]      c_eff, w_eff, eff_n;
    logic [AW-1:0]   mem [STACK_DEPTH];
    logic [PW-1:0]   sp, sp_inc, sp_dec;
    logic [CW-1:0]   cnt;
    logic [2:0]      s30, s40, s90, s100;
    logic            acc;

    assign acc    = cmd_valid && cmd_ready;
    assign sp_inc = (sp == PW'(STACK_DEPTH - 1)) ? '0 : sp + 1'b1;
    assign sp_dec = (sp == '0) ? PW'(STACK_DEPTH - 1) : sp - 1'b1;

    // Interpretation of one parameter against the working set
    always_comb begin
        fg_n  = w_fg;
        bg_n  = w_bg;
        eff_n = w_eff;
        st_n  = st;
        s30   = 3'(pn - 8'd30);
        s40   = 3'(pn - 8'd40);
        s90   = 3'(pn - 8'd90);
        s100  = 3'(pn - 8'd100);
        case (st)
            S_START: begin
                case (pn) inside
                    8'd0: begin
                        fg_n  = DEFAULT_FG;
                        bg_n  = DEFAULT_BG;
                        eff_n = '0;
                    end
                    8'd1:  eff_n[0] = 1'b1;
                    8'd2:  eff_n[1] = 1'b1;
                    8'd3:  eff_n[2] = 1'b1;
                    8'd4:  eff_n[3] = 1'b1;
                    8'd5:  eff_n[4] = 1'b1;
                    8'd7:  eff_n[5] = 1'b1;
                    8'd8:  eff_n[6] = 1'b1;
                    8'd9:  eff_n[7] = 1'b1;
                    8'd22: eff_n[1:0] = 2'b00;
                    8'd23: eff_n[2] = 1'b0;
                    8'd24: eff_n[3] = 1'b0;
                    8'd25: eff_n[4] = 1'b0;
                    8'd27: eff_n[5] = 1'b0;
                    8'd28: eff_n[6] = 1'b0;
                    8'd29: eff_n[7] = 1'b0;
                    [8'd30:8'd36]:   fg_n = mapc(s30, LVL_NORM);
                    [8'd40:8'd46]:   bg_n = mapc(s40, LVL_NORM);
                    8'd37:           fg_n = mapc(3'd7, LVL_WHITE);
                    8'd47:           bg_n = mapc(3'd7, LVL_WHITE);
                    8'd39:           fg_n = DEFAULT_FG;
                    8'd49:           bg_n = DEFAULT_BG;
                    [8'd90:8'd97]:   fg_n = mapc(s90, LVL_BRIGHT);
                    [8'd100:8'd107]: bg_n = mapc(s100, LVL_BRIGHT);
                    8'd38:           st_n = S_FG_SEL;
                    8'd48:           st_n = S_BG_SEL;
                    default: ;
                endcase
            end
            S_FG_SEL: st_n = (pn == 8'd5) ? S_FG_IDX : (pn == 8'd2) ? S_FG_R : S_START;
            S_BG_SEL: st_n = (pn == 8'd5) ? S_BG_IDX : (pn == 8'd2) ? S_BG_R : S_START;
            S_FG_IDX: begin fg_n = palette(pn); st_n = S_START; end
            S_BG_IDX: begin bg_n = palette(pn); st_n = S_START; end
            S_FG_R:   begin fg_n[CL-1 -: CH_BITS]        = top(pn); st_n = S_FG_G;  end
            S_FG_G:   begin fg_n[2*CH_BITS-1 -: CH_BITS] = top(pn); st_n = S_FG_B;  end
            S_FG_B:   begin fg_n[CH_BITS-1:0]            = top(pn); st_n = S_START; end
            S_BG_R:   begin bg_n[CL-1 -: CH_BITS]        = top(pn); st_n = S_BG_G;  end
            S_BG_G:   begin bg_n[2*CH_BITS-1 -: CH_BITS] = top(pn); st_n = S_BG_B;  end
            S_BG_B:   begin bg_n[CH_BITS-1:0]            = top(pn); st_n = S_START; end
            default:  st_n = S_START;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= S_START;
            c_fg        <= DEFAULT_FG;
            c_bg        <= DEFAULT_BG;
            c_eff       <= '0;
            w_fg        <= DEFAULT_FG;
            w_bg        <= DEFAULT_BG;
            w_eff       <= '0;
            cmd_ready   <= 1'b1;
            attr_update <= 1'b0;
            sp          <= '0;
            cnt         <= '0;
        end else begin
            attr_update <= 1'b0;
            if (!cmd_ready) begin
                // commit cycle following an accepted END
                c_fg        <= w_fg;
                c_bg        <= w_bg;
                c_eff       <= w_eff;
                attr_update <= 1'b1;
                cmd_ready   <= 1'b1;
            end else if (acc) begin
                case (cmd_op)
                    OP_INIT: begin
                        w_fg  <= c_fg;
                        w_bg  <= c_bg;
                        w_eff <= c_eff;
                        st    <= S_START;
                    end
                    OP_PARAM, OP_END: begin
                        w_fg  <= fg_n;
                        w_bg  <= bg_n;
                        w_eff <= eff_n;
                        st    <= st_n;
                        if (cmd_op == OP_END) cmd_ready <= 1'b0;
                    end
                    OP_CLEAR: begin
                        c_fg        <= DEFAULT_FG;
                        c_bg        <= DEFAULT_BG;
                        c_eff       <= '0;
                        w_fg        <= DEFAULT_FG;
                        w_bg        <= DEFAULT_BG;
                        w_eff       <= '0;
                        st          <= S_START;
                        attr_update <= 1'b1;
                    end
                    OP_SAVE: begin
                        sp <= sp_inc;
                        if (cnt != CW'(STACK_DEPTH)) cnt <= cnt + 1'b1;
                    end
                    OP_RESTORE: begin
                        if (cnt != '0) begin
                            {c_fg, c_bg, c_eff} <= mem[sp_dec];
                            sp  <= sp_dec;
                            cnt <= cnt - 1'b1;
                        end else begin
                            c_fg  <= DEFAULT_FG;
                            c_bg  <= DEFAULT_BG;
                            c_eff <= '0;
                        end
                        attr_update <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Full stack overwrites the oldest slot because sp wraps around
    always_ff @(posedge clk) begin
        if (acc && cmd_op == OP_SAVE) mem[sp] <= {c_fg, c_bg, c_eff};
    end

    assign fg          = c_fg;
    assign bg          = c_bg;
    assign effects     = c_eff;
    assign stack_count = cnt;

endmodule
